ring_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among N requesters, using a one-hot rotating token (ring-counter style) as the priority pointer. Each grant holds until the holder releases. The token then advances one position past the holder, so every requester is served within N grants. The block sits between the requesting sequencers and the shared datapath and is the sole source of its select lines.

---
 rtl/ring_arb_pkg.sv | 26 ++
 rtl/ring_rr_pick.sv | 28 ++
 rtl/ring_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_ring_rr_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
// ring_arb_pkg: shared types and helpers for the ring round-robin arbiter.
//   state_e : arbiter FSM states (StIdle, StGranted)
//   MaxN    : widest requester vector the helpers support
//   rotl1   : rotate an n-bit vector left by one (bit n-1 wraps to bit 0)
package ring_arb_pkg;

  localparam int unsigned MaxN = 16;

  typedef enum logic {
    StIdle    = 1'b0,
    StGranted = 1'b1
  } state_e;

  // Only the low n bits of v are meaningful; the result is zero above bit n-1.
  function automatic logic [MaxN-1:0] rotl1(input logic [MaxN-1:0] v, input int unsigned n);
    logic [MaxN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (i < n) begin
        r[(i + 1) % n] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_rr_pick.sv
// ring_rr_pick: combinational circular priority pick.
// Returns the first set request bit at or above the token position, wrapping
// from bit N-1 back to bit 0.
//   i_req   [N-1:0] : request vector
//   i_token [N-1:0] : one-hot priority pointer
//   o_pick  [N-1:0] : one-hot winner (zero when no request)
//   o_valid         : any request present
module ring_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_token,
  output logic [N-1:0] o_pick,
  output logic         o_valid
);

  logic [2*N-1:0] w_dbl_req;
  logic [2*N-1:0] w_dbl_pick;

  // Subtracting the token from the doubled request clears the lowest set bit
  // at or above the token; masking with the inverse isolates exactly that bit.
  // The upper copy supplies the wrap-around candidates.
  assign w_dbl_req  = {i_req, i_req};
  assign w_dbl_pick = w_dbl_req & ~(w_dbl_req - {{N{1'b0}}, i_token});
  assign o_pick     = w_dbl_pick[N-1:0] | w_dbl_pick[2*N-1:N];
  assign o_valid    = |i_req;

endmodule

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter with a one-hot rotating token.
// A grant is held until the holder releases (done, or drops its request);
// the token then moves one position past the holder.
// Optional feature macro RING_ARB_TIMEOUT_EN: forces a release after
// MAX_HOLD granted cycles and pulses o_timeout for one cycle.
//   i_clk           : clock, all state on posedge
//   i_reset         : synchronous active-high reset
//   i_req   [N-1:0] : level requests, held until served
//   i_done          : holder release strobe, only looked at while granted
//   o_gnt   [N-1:0] : registered one-hot grant, zero when idle
//   o_busy          : any grant bit high
//   o_token [N-1:0] : registered one-hot priority pointer
//   o_timeout       : one-cycle pulse after a forced release
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_req,
  input  logic         i_done,
  output logic [N-1:0] o_gnt,
  output logic         o_busy,
  output logic [N-1:0] o_token,
  output logic         o_timeout
);

  state_e       r_state;
  logic [N-1:0] r_gnt;
  logic [N-1:0] r_token;

  state_e       w_state_nxt;
  logic [N-1:0] w_gnt_nxt;
  logic [N-1:0] w_token_nxt;
  logic [N-1:0] w_pick;
  logic         w_pick_valid;
  logic         w_release;
  logic         w_force;

  ring_rr_pick #(
    .N (N)
  ) u_pick (
    .i_req   (i_req),
    .i_token (r_token),
    .o_pick  (w_pick),
    .o_valid (w_pick_valid)
  );

  // Normal release: explicit done or the holder has withdrawn its request.
  assign w_release = i_done | ~(|(i_req & r_gnt));

`ifdef RING_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

  logic [CntW-1:0] r_hold;
  logic            r_timeout;

  // A done on the limit edge counts as a normal release, so no timeout pulse.
  assign w_force = (r_state == StGranted) && !w_release &&
                   (r_hold == CntW'(MAX_HOLD - 1));

  // Held at zero while idle so it starts from zero on every grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (r_state == StGranted && !w_release && !w_force) begin
        r_hold <= r_hold + CntW'(1);
      end else begin
        r_hold <= '0;
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_force   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_token_nxt = r_token;
    unique case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_state_nxt = StGranted;
          w_gnt_nxt   = w_pick;
        end
      end
      StGranted: begin
        if (w_release || w_force) begin
          w_state_nxt = StIdle;
          w_gnt_nxt   = '0;
          w_token_nxt = N'(rotl1(MaxN'(r_gnt), N));
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_token <= N'(1);
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_token <= w_token_nxt;
    end
  end

  assign o_gnt   = r_gnt;
  assign o_busy  = |r_gnt;
  assign o_token = r_token;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 16;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic         busy;
  logic [N-1:0] token;
  logic         timeout;

  ring_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_req     (req),
    .i_done    (done),
    .o_gnt     (gnt),
    .o_busy    (busy),
    .o_token   (token),
    .o_timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: holder index (-1 when idle), token index, cycles held.
  int m_holder = -1;
  int m_tok    = 0;
  int m_held   = 0;
  int m_to     = 0;
  int m_rel    = 0;

`ifdef RING_ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [N-1:0] rq, input logic dn);
    bit rel;
    bit frc;
    m_to = 0;
    if (rst) begin
      m_holder = -1;
      m_tok    = 0;
      m_held   = 0;
    end else if (m_holder < 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_tok + k) % N;
        if (rq[idx] && m_holder < 0) begin
          m_holder = idx;
          m_held   = 1;
        end
      end
    end else begin
      rel = dn || !rq[m_holder];
      frc = TimeoutOn && !rel && (m_held == MAX_HOLD);
      if (rel || frc) begin
        m_tok    = (m_holder + 1) % N;
        m_holder = -1;
        m_to     = frc ? 1 : 0;
        m_rel++;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [N-1:0] rq, input logic dn);
    logic [N-1:0] eg;
    reset = rst;
    req   = rq;
    done  = dn;
    @(posedge clk);
    model_edge(rst, rq, dn);
    #1;
    eg = (m_holder < 0) ? '0 : N'(1 << m_holder);
    check("gnt", 32'(gnt), 32'(eg));
    check("busy", 32'(busy), 32'(m_holder >= 0));
    check("token", 32'(token), 32'(1 << m_tok));
    check("timeout", 32'(timeout), 32'(m_to));
  endtask

  logic [N-1:0] seq_q[$];
  logic [N-1:0] exp_seq[5];
  logic [N-1:0] prev_g;
  logic [N-1:0] rq;
  int run, tcnt, cyc;
  bit counting;

  initial begin
    reset = 1'b1;
    req   = '0;
    done  = 1'b0;

    // Reset, then idle with no requests.
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);

    // Full load, done on the third cycle of each grant.
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    m_rel  = 0;
    prev_g = '0;
    cyc    = 0;
    while (m_rel < 5 && cyc < 100) begin
      step(1'b0, 4'b1111, (m_holder >= 0) && (m_held == 3));
      if (gnt != '0 && prev_g == '0) seq_q.push_back(gnt);
      prev_g = gnt;
      cyc++;
    end
    check("seq_bound", 32'(m_rel), 32'd5);
    check("seq_len", 32'(seq_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < seq_q.size()) check("seq_gnt", 32'(seq_q[i]), 32'(exp_seq[i]));
    end
    check("seq_tok", 32'(token), 32'b0010);

    // Wrap-around: token at bit 2, requests only on bits 0 and 1.
    step(1'b1, '0, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0010, 1'b1);
    check("wrap_tok0", 32'(token), 32'b0100);
    step(1'b0, 4'b0011, 1'b0);
    check("wrap_gnt", 32'(gnt), 32'b0001);
    step(1'b0, 4'b0011, 1'b1);
    check("wrap_tok1", 32'(token), 32'b0010);

    // Holder withdraws its request without done.
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    check("drop_gnt", 32'(gnt), 32'd0);
    check("drop_tok", 32'(token), 32'b1000);

    // Sole requester that never releases.
    step(1'b1, '0, 1'b0);
    run = 0; tcnt = 0; counting = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 4'b0001, 1'b0);
      if (timeout) tcnt++;
      if (counting && gnt == 4'b0001) run++;
      else if (run > 0) counting = 1'b0;
    end
    check("hold_run", 32'(run), TimeoutOn ? 32'd16 : 32'd40);
    check("to_cnt", 32'(tcnt), TimeoutOn ? 32'd2 : 32'd0);

    // Reset in the second cycle of a grant.
    step(1'b1, '0, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    step(1'b1, 4'b0100, 1'b0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_tok", 32'(token), 32'b0001);
    step(1'b0, 4'b0100, 1'b0);
    check("rst_regnt", 32'(gnt), 32'b0100);

    // Randomized traffic with sticky requests so long holds and timeouts occur.
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom_range(0, 15));
      if (m_holder >= 0 && $urandom_range(0, 3) != 0) rq[m_holder] = 1'b1;
      step($urandom_range(0, 199) == 0, rq, $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
